// File: rtl/glyph_rom_arbiter.sv
// glyph_rom_arbiter: round-robin arbiter sharing one glyph ROM port among N_REQ requesters.
// Define GLYPH_ARB_PRIORITY_EN to give requester 0 absolute priority over a round-robin of the rest.
module glyph_rom_arbiter #(
   parameter int N_REQ   = 4,
   parameter int ROM_LAT = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [6*N_REQ-1:0]   req_txt_addr,
   input  logic [3*N_REQ-1:0]   req_h_point,
   input  logic [3*N_REQ-1:0]   req_v_point,
   output logic [N_REQ-1:0]     req_ready,
   output logic [5:0]           rom_txt_addr,
   output logic [2:0]           rom_h_point,
   output logic [2:0]           rom_v_point,
   input  logic [11:0]          rom_pixel,
   output logic                 rsp_valid,
   output logic [2:0]           rsp_id,
   output logic [11:0]          rsp_pixel
);
`ifdef GLYPH_ARB_PRIORITY_EN
   localparam logic [2:0] RR_RST = 3'd1;
`else
   localparam logic [2:0] RR_RST = 3'd0;
`endif
   logic [2:0]               r_rr_ptr;
   logic [5:0]               r_txt;
   logic [2:0]               r_h;
   logic [2:0]               r_v;
   logic [ROM_LAT:0]         r_vld;
   logic [ROM_LAT:0]         r_oor;
   logic [ROM_LAT:0][2:0]    r_id;
   logic [7:0]               w_vld8;
   logic [2:0]               w_cand;
   logic [2:0]               w_gidx;
   logic [2:0]               w_rr_next;
   logic                     w_found;
   logic                     w_accept;
   logic                     w_oor;
   logic [5:0]               w_txt;
   logic [2:0]               w_h;
   logic [2:0]               w_v;

   assign w_vld8 = 8'(req_valid);

   always_comb begin
      w_found = 1'b0;
      w_gidx  = '0;
      w_cand  = '0;
`ifdef GLYPH_ARB_PRIORITY_EN
      w_found = w_vld8[0];
      for (int k = 0; k < N_REQ - 1; k++) begin
         w_cand = 3'(1 + (int'(r_rr_ptr) - 1 + k) % (N_REQ - 1));
         if (!w_found && w_vld8[w_cand]) begin
            w_found = 1'b1;
            w_gidx  = w_cand;
         end
      end
      w_rr_next = (w_gidx == 3'd0) ? r_rr_ptr : (w_gidx == 3'(N_REQ - 1)) ? 3'd1 : w_gidx + 3'd1;
`else
      for (int k = 0; k < N_REQ; k++) begin
         w_cand = 3'((int'(r_rr_ptr) + k) % N_REQ);
         if (!w_found && w_vld8[w_cand]) begin
            w_found = 1'b1;
            w_gidx  = w_cand;
         end
      end
      w_rr_next = (w_gidx == 3'(N_REQ - 1)) ? 3'd0 : w_gidx + 3'd1;
`endif
   end

   assign w_accept  = w_found & ~rst;
   assign req_ready = w_accept ? N_REQ'(1 << w_gidx) : '0;
   assign w_txt     = 6'(req_txt_addr >> (6 * w_gidx));
   assign w_h       = 3'(req_h_point >> (3 * w_gidx));
   assign w_v       = 3'(req_v_point >> (3 * w_gidx));
   assign w_oor     = (w_txt > 6'd35) | (w_h > 3'd4) | (w_v > 3'd6);

   // Out-of-range flag rides alongside the id so the ROM data can be masked at the output
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr_ptr <= RR_RST;
         r_txt    <= '0;
         r_h      <= '0;
         r_v      <= '0;
         r_vld    <= '0;
         r_oor    <= '0;
         r_id     <= '0;
      end else begin
         if (w_accept) begin
            r_rr_ptr <= w_rr_next;
            r_txt    <= w_txt;
            r_h      <= w_h;
            r_v      <= w_v;
         end
         r_vld <= {r_vld[ROM_LAT-1:0], w_accept};
         r_oor <= {r_oor[ROM_LAT-1:0], w_oor};
         r_id  <= {r_id[ROM_LAT-1:0], w_gidx};
      end
   end

   assign rom_txt_addr = r_txt;
   assign rom_h_point  = r_h;
   assign rom_v_point  = r_v;
   assign rsp_valid    = r_vld[ROM_LAT];
   assign rsp_id       = rsp_valid ? r_id[ROM_LAT] : 3'd0;
   assign rsp_pixel    = (rsp_valid && !r_oor[ROM_LAT]) ? rom_pixel : 12'h000;
endmodule

// File: tb/tb_glyph_rom_arbiter.sv
// tb_glyph_rom_arbiter: scoreboard bench for glyph_rom_arbiter with a synchronous glyph ROM model.
module tb_glyph_rom_arbiter;
   localparam int N   = 4;
   localparam int LAT = 1;
`ifdef GLYPH_ARB_PRIORITY_EN
   localparam int RR0 = 1;
`else
   localparam int RR0 = 0;
`endif
   typedef struct {
      int          due;
      logic [2:0]  id;
      logic [11:0] pix;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   req_valid = '0;
   logic [6*N-1:0] req_txt_addr = '0;
   logic [3*N-1:0] req_h_point = '0;
   logic [3*N-1:0] req_v_point = '0;
   logic [N-1:0]   req_ready;
   logic [5:0]     rom_txt_addr;
   logic [2:0]     rom_h_point;
   logic [2:0]     rom_v_point;
   logic [11:0]    rom_pixel;
   logic           rsp_valid;
   logic [2:0]     rsp_id;
   logic [11:0]    rsp_pixel;
   logic [11:0]    rom_q [LAT];

   exp_t        sb[$];
   int          glog[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          rr_m = RR0;
   int          g;
   int          got;
   logic [11:0] m_rom = '0;
   logic [5:0]  mt;
   logic [2:0]  mh;
   logic [2:0]  mv;

   always #5 clk = ~clk;

   glyph_rom_arbiter #(.N_REQ(N), .ROM_LAT(LAT)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_txt_addr(req_txt_addr),
      .req_h_point(req_h_point), .req_v_point(req_v_point), .req_ready(req_ready),
      .rom_txt_addr(rom_txt_addr), .rom_h_point(rom_h_point), .rom_v_point(rom_v_point),
      .rom_pixel(rom_pixel), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_pixel(rsp_pixel)
   );

   function automatic logic [11:0] glyph(logic [5:0] t, logic [2:0] h, logic [2:0] v);
      return {t, h, v} ^ 12'hEAF;
   endfunction

   always_ff @(posedge clk) begin
      rom_q[0] <= glyph(rom_txt_addr, rom_h_point, rom_v_point);
      for (int i = 1; i < LAT; i++) rom_q[i] <= rom_q[i-1];
   end
   assign rom_pixel = rom_q[LAT-1];

   task automatic check(string tag, logic [31:0] got_v, logic [31:0] exp_v);
      checks++;
      if (got_v !== exp_v) begin
         errors++;
         $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got_v, exp_v, cyc);
      end
   endtask

   function automatic int exp_grant(logic [N-1:0] v, int rr);
`ifdef GLYPH_ARB_PRIORITY_EN
      if (v[0]) return 0;
      for (int k = 0; k < N - 1; k++) begin
         int c = 1 + (rr - 1 + k) % (N - 1);
         if (((v >> c) & 1) != 0) return c;
      end
`else
      for (int k = 0; k < N; k++) begin
         int c = (rr + k) % N;
         if (((v >> c) & 1) != 0) return c;
      end
`endif
      return -1;
   endfunction

   // Reference model: response due check, ROM address tracking and grant prediction each cycle
   always @(negedge clk) begin
      cyc++;
      if (sb.size() > 0 && sb[0].due == cyc) begin
         check("rsp_valid", 32'(rsp_valid), 1);
         check("rsp_id", 32'(rsp_id), 32'(sb[0].id));
         check("rsp_pixel", 32'(rsp_pixel), 32'(sb[0].pix));
         void'(sb.pop_front());
      end else
         check("rsp_idle", {rsp_valid, rsp_id, rsp_pixel}, 0);
      check("rom_addr", {rom_txt_addr, rom_h_point, rom_v_point}, 32'(m_rom));
      for (int i = 0; i < N; i++) if (((req_ready >> i) & 1) != 0) glog.push_back(i);
      if (rst) begin
         check("ready_in_rst", 32'(req_ready), 0);
         sb.delete();
         rr_m  = RR0;
         m_rom = '0;
      end else begin
         g = exp_grant(req_valid, rr_m);
         check("ready", 32'(req_ready), (g < 0) ? 0 : (1 << g));
         if (g >= 0) begin
            mt = 6'(req_txt_addr >> (6 * g));
            mh = 3'(req_h_point >> (3 * g));
            mv = 3'(req_v_point >> (3 * g));
            sb.push_back('{due: cyc + LAT + 1, id: 3'(g),
                           pix: (mt > 35 || mh > 4 || mv > 6) ? 12'h000 : glyph(mt, mh, mv)});
            m_rom = {mt, mh, mv};
`ifdef GLYPH_ARB_PRIORITY_EN
            if (g != 0) rr_m = (g == N - 1) ? 1 : g + 1;
`else
            rr_m = (g + 1) % N;
`endif
         end
      end
   end

   task automatic rand_fields();
      for (int i = 0; i < N; i++) begin
         req_txt_addr = (req_txt_addr << 6) | (6*N)'($urandom_range(0, 44));
         req_h_point  = (req_h_point << 3) | (3*N)'($urandom_range(0, 5));
         req_v_point  = (req_v_point << 3) | (3*N)'($urandom_range(0, 7));
      end
   endtask

   task automatic set_req(int i, int t, int h, int v);
      req_valid    = N'(1 << i);
      req_txt_addr = (6*N)'(t) << (6 * i);
      req_h_point  = (3*N)'(h) << (3 * i);
      req_v_point  = (3*N)'(v) << (3 * i);
   endtask

   task automatic step(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic single(string tag, int i, int t, int h, int v, logic [11:0] pix);
      set_req(i, t, h, v);
      step(1);
      req_valid = '0;
      repeat (LAT) @(posedge clk);
      @(negedge clk);
      check({tag, "_valid"}, 32'(rsp_valid), 1);
      check({tag, "_id"}, 32'(rsp_id), 32'(i));
      check({tag, "_pixel"}, 32'(rsp_pixel), 32'(pix));
      step(2);
   endtask

   initial begin
      step(3);
      rst = 1'b0;
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      check("rst_rom_addr", {rom_txt_addr, rom_h_point, rom_v_point}, 0);

      glog.delete();
      req_valid = '1;
      repeat (8) begin
         rand_fields();
         step(1);
      end
      req_valid = '0;
      check("rr_grant_count", 32'(glog.size()), 8);
      for (int i = 0; i < 8 && i < glog.size(); i++)
`ifdef GLYPH_ARB_PRIORITY_EN
         check("prio_grant", 32'(glog[i]), 0);
`else
         check("rr_grant", 32'(glog[i]), 32'(i % N));
`endif
      step(LAT + 2);

      single("abc", 2, 16, 2, 3, 12'hABC);
      single("txt40", 1, 40, 1, 1, 12'h000);
      single("h5", 3, 5, 5, 1, 12'h000);
      single("v7", 0, 7, 0, 7, 12'h000);
      single("edge", 1, 35, 4, 6, glyph(6'd35, 3'd4, 3'd6));

      req_valid = '1;
      repeat (3) begin
         rand_fields();
         step(1);
      end
      req_valid = '0;
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      repeat (4) begin
         @(negedge clk);
         check("post_rst_quiet", 32'(rsp_valid), 0);
      end
      step(1);
      req_valid = 4'b0110;
      @(negedge clk);
      check("post_rst_grant", 32'(req_ready), 4'b0010);
      step(1);
      req_valid = '0;
      step(LAT + 2);

      repeat (300) begin
         req_valid = N'($urandom);
         rand_fields();
         step(1);
      end
      req_valid = '0;
      step(LAT + 2);

`ifdef GLYPH_ARB_PRIORITY_EN
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      glog.delete();
      req_valid = '1;
      step(6);
      req_valid = 4'b1110;
      step(4);
      req_valid = '0;
      check("prio_count", 32'(glog.size()), 10);
      for (int i = 0; i < 10 && i < glog.size(); i++)
         check("prio_seq", 32'(glog[i]), (i < 6) ? 0 : ((i - 6) % 3) + 1);
      step(LAT + 2);
`else
      repeat (6) begin
         req_valid = N'($urandom) & ~N'(1 << (N - 1));
         step($urandom_range(1, 3));
         got = 0;
         for (int k = 0; k < N && got == 0; k++) begin
            req_valid = N'($urandom) | N'(1 << (N - 1));
            rand_fields();
            @(negedge clk);
            if (req_ready[N-1]) got = 1;
            step(1);
         end
         check("req3_grant", 32'(got), 1);
         req_valid = '0;
         step(1);
      end
      step(LAT + 2);
`endif

      check("sb_drained", 32'(sb.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/glyph_rom_arbiter.md
GLYPH_ROM_ARBITER -- requirements
Module: glyph_rom_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, meaning the number of requesters (2..8).
REQ-002 The block SHALL have parameter ROM_LAT, default 1, meaning the fixed glyph ROM read latency in cycles (1..3).
REQ-003 The block SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port req_valid  input  N_REQ  per-requester read request.
REQ-006 The block SHALL have port req_txt_addr  input  6*N_REQ  packed glyph index per requester.
REQ-007 The block SHALL have port req_h_point  input  3*N_REQ  packed glyph column per requester (0..4).
REQ-008 The block SHALL have port req_v_point  input  3*N_REQ  packed glyph row per requester (0..6).
REQ-009 The block SHALL have port req_ready  output  N_REQ  grant; a request is accepted when valid and ready are both high.
REQ-010 The block SHALL have port rom_txt_addr / rom_h_point / rom_v_point  output  6/3/3  glyph ROM address port.
REQ-011 The block SHALL have port rom_pixel  input  12  ROM data, valid ROM_LAT cycles after the address.
REQ-012 The block SHALL have port rsp_valid  output  1  response strobe.
REQ-013 The block SHALL have port rsp_id  output  3  index of the requester owning the response.
REQ-014 The block SHALL have port rsp_pixel  output  12  returned RGB444 pixel.

Function
REQ-015 req_ready SHALL be combinational, at most one-hot, and nonzero whenever any req_valid bit is high.
REQ-016 Arbitration SHALL be round-robin: the search starts at rr_ptr, and after each accept rr_ptr becomes (granted index + 1) mod N_REQ.
REQ-017 rr_ptr SHALL hold its value in cycles with no accept.
REQ-018 The ROM address outputs SHALL be registered from the granted request, one cycle after the accept.
REQ-019 The ROM address outputs SHALL hold their last value when no accept occurs.
REQ-020 rsp_valid, rsp_id and rsp_pixel SHALL appear exactly ROM_LAT+1 cycles after the accept cycle.
REQ-021 The id and valid pipeline SHALL be shift-register tracked.
REQ-022 The arbiter SHALL accept one request per cycle with no bubbles (throughput 1).
REQ-023 Requests with txt_addr>35, h_point>4 or v_point>6 SHALL still be accepted and occupy a slot.
REQ-024 Such out-of-range requests SHALL return rsp_pixel=12'h000, not the ROM data.
REQ-025 A requester that deasserts req_valid before being granted SHALL lose nothing and leave rr_ptr unchanged.
REQ-026 A requester whose req_valid stays high SHALL be granted within N_REQ cycles.
REQ-027 rsp_pixel and rsp_id SHALL be 0 whenever rsp_valid is 0.

Reset
REQ-028 On rst high at a clock edge: rr_ptr=0, ROM address outputs=0, all pipeline valid bits=0, rsp_valid=0, rsp_id=0, rsp_pixel=0.
REQ-029 req_ready SHALL be all zero while rst is high.
REQ-030 Reset asserted mid-operation SHALL discard in-flight reads; no response for them SHALL appear after reset releases.
REQ-031 The first grant after reset release SHALL follow normal arbitration with rr_ptr=0.

Configuration
REQ-032 With macro GLYPH_ARB_PRIORITY_EN defined, requester 0 SHALL have fixed absolute priority whenever its req_valid is high.
REQ-033 With GLYPH_ARB_PRIORITY_EN defined, requesters 1..N_REQ-1 SHALL be round-robin among themselves, and rr_ptr SHALL never point at 0.
REQ-034 With GLYPH_ARB_PRIORITY_EN undefined, all requesters SHALL be pure round-robin per REQ-016.

Verification
REQ-035 Reset, then req_valid=4'b1111 held for 8 cycles -> grants 0,1,2,3,0,1,2,3; rsp_id follows the same order, ROM_LAT+1 cycles later.
REQ-036 Single request: req_valid=4'b0100, addr 16, h=2, v=3, ROM model returns 12'hABC -> rsp_valid at cycle+2 (ROM_LAT=1), rsp_id=2, rsp_pixel=12'hABC.
REQ-037 Request with txt_addr=40 -> accepted; rsp_pixel=12'h000 at the normal latency.
REQ-038 Burst of 3 accepts, then rst pulsed for 1 cycle before the responses appear -> no rsp_valid for 4 cycles after reset; next grant goes to the lowest valid index.
REQ-039 GLYPH_ARB_PRIORITY_EN defined, req_valid=4'b1111 for 6 cycles -> all grants go to 0; then req_valid=4'b1110 -> grants 1,2,3,1.
REQ-040 Requester 3 held for 4 cycles while 0..2 toggle randomly -> requester 3 is granted within 4 cycles (macro undefined).
